// File: rtl/seq_pattern_monitor.sv
// rtl/seq_pattern_monitor.sv - run-time programmable input-sequence detector
//
// Purpose: tracks an NUM_IN-bit input vector through a programmable table of
// up to MAX_STEPS care-mask/value steps. Progress advances when the current
// step matches. It holds while the previous step still matches, and it falls
// back to zero otherwise. Flags completion (match/done), loss of progress (fail)
// and, optionally, a stalled step (timeout).
//
// Optional feature macro: HOLD_TIMEOUT_EN (hold-cycle limit of TIMEOUT_CYC).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   enable          evaluate when 1, freeze state when 0
//   in_vec          monitored inputs
//   cfg_we          write step table entry cfg_addr with cfg_mask/cfg_val
//   cfg_len_we      write sequence length cfg_len (clamped) and cfg_rearm
//   progress        steps matched so far
//   busy            progress != 0 and not done
//   match           one-cycle pulse on sequence completion
//   done            sequence complete and parked (rearm=0)
//   fail            one-cycle pulse when partial progress is lost
//   timeout         one-cycle pulse on hold-limit expiry
module seq_pattern_monitor #(
  parameter int NUM_IN      = 4,
  parameter int MAX_STEPS   = 16,
  parameter int STEP_W      = $clog2(MAX_STEPS),
  parameter int LEN_W       = $clog2(MAX_STEPS + 1),
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_IN-1:0] in_vec,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [NUM_IN-1:0] cfg_mask,
  input  logic [NUM_IN-1:0] cfg_val,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_rearm,
  output logic [LEN_W-1:0]  progress,
  output logic              busy,
  output logic              match,
  output logic              done,
  output logic              fail,
  output logic              timeout
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_STEPS);

  logic [NUM_IN-1:0] mask_q [MAX_STEPS];
  logic [NUM_IN-1:0] val_q  [MAX_STEPS];
  logic [LEN_W-1:0]  len_q;
  logic              rearm_q;

  logic [LEN_W-1:0]  p_q, p_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;

  logic [STEP_W-1:0] step_idx;
  logic [STEP_W-1:0] prev_idx;
  logic              c_cur;
  logic              c_prev;
  logic              cfg_wr;

`ifdef HOLD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] hold_q, hold_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  // p never indexes the table once it reaches len, so the low bits suffice.
  assign step_idx = p_q[STEP_W-1:0];
  assign prev_idx = step_idx - STEP_W'(1);
  assign c_cur    = (((in_vec ^ val_q[step_idx]) & mask_q[step_idx]) == '0);
  assign c_prev   = (((in_vec ^ val_q[prev_idx]) & mask_q[prev_idx]) == '0);
  assign cfg_wr   = cfg_we | cfg_len_we;

  always_comb begin
    p_d       = p_q;
    done_d    = done_q;
    match_d   = 1'b0;
    fail_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef HOLD_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    if (cfg_wr) begin
      // Reconfiguration silently restarts the sequence, even mid-match.
      p_d    = '0;
      done_d = 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hold_d = '0;
`endif
    end else if (enable && (len_q != '0) && !done_q) begin
      if (c_cur) begin
`ifdef HOLD_TIMEOUT_EN
        hold_d = '0;
`endif
        if ((p_q + LEN_W'(1)) == len_q) begin
          match_d = 1'b1;
          if (rearm_q) begin
            p_d = '0;
          end else begin
            p_d    = len_q;
            done_d = 1'b1;
          end
        end else begin
          p_d = p_q + LEN_W'(1);
        end
      end else if ((p_q != '0) && c_prev) begin
`ifdef HOLD_TIMEOUT_EN
        if (hold_q == HOLD_LAST) begin
          p_d       = '0;
          timeout_d = 1'b1;
          hold_d    = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
`endif
      end else begin
        fail_d = (p_q != '0);
        p_d    = '0;
`ifdef HOLD_TIMEOUT_EN
        hold_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_STEPS; i++) begin
        mask_q[i] <= '0;
        val_q[i]  <= '0;
      end
      len_q     <= '0;
      rearm_q   <= 1'b0;
      p_q       <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      if (cfg_we) begin
        mask_q[cfg_addr] <= cfg_mask;
        val_q[cfg_addr]  <= cfg_val;
      end
      if (cfg_len_we) begin
        len_q   <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        rearm_q <= cfg_rearm;
      end
      p_q       <= p_d;
      done_q    <= done_d;
      match_q   <= match_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
`ifdef HOLD_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign progress = p_q;
  assign busy     = (p_q != '0) && !done_q;
  assign match    = match_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_seq_pattern_monitor.sv
// tb/tb_seq_pattern_monitor.sv - self-checking bench for seq_pattern_monitor
module tb_seq_pattern_monitor;

  localparam int NI   = 4;
  localparam int MS   = 16;
  localparam int SW   = 4;
  localparam int LW   = 5;
  localparam int TOC  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [NI-1:0] in_vec = '0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_addr = '0;
  logic [NI-1:0] cfg_mask = '0;
  logic [NI-1:0] cfg_val = '0;
  logic          cfg_len_we = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_rearm = 1'b0;
  logic [LW-1:0] progress;
  logic          busy, match, done, fail, timeout;

  seq_pattern_monitor #(
    .NUM_IN(NI), .MAX_STEPS(MS), .STEP_W(SW), .LEN_W(LW), .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_vec(in_vec),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_val(cfg_val),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_rearm(cfg_rearm),
    .progress(progress), .busy(busy), .match(match), .done(done),
    .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers describing where in the sequence we are.
  int mask_m [MS];
  int val_m  [MS];
  int len_m = 0, stage = 0, holds = 0;
  bit rearm_m = 0, parked = 0;
  bit exp_match = 0, exp_fail = 0, exp_timeout = 0;

  function automatic bit step_ok(input int s, input int v);
    return ((v ^ val_m[s]) & mask_m[s]) == 0;
  endfunction

  always @(posedge clk) begin
    int v;
    v = int'(in_vec);
    exp_match = 0; exp_fail = 0; exp_timeout = 0;
    if (reset) begin
      for (int i = 0; i < MS; i++) begin mask_m[i] = 0; val_m[i] = 0; end
      len_m = 0; rearm_m = 0; stage = 0; parked = 0; holds = 0;
    end else if (cfg_we || cfg_len_we) begin
      if (cfg_we) begin mask_m[cfg_addr] = int'(cfg_mask); val_m[cfg_addr] = int'(cfg_val); end
      if (cfg_len_we) begin
        len_m   = (int'(cfg_len) > MS) ? MS : int'(cfg_len);
        rearm_m = cfg_rearm;
      end
      stage = 0; parked = 0; holds = 0;
    end else if (enable && len_m > 0 && !parked) begin
      if (step_ok(stage, v)) begin
        holds = 0;
        if (stage + 1 == len_m) begin
          exp_match = 1;
          if (rearm_m) stage = 0;
          else begin stage = len_m; parked = 1; end
        end else stage = stage + 1;
      end else if (stage > 0 && step_ok(stage - 1, v)) begin
`ifdef HOLD_TIMEOUT_EN
        holds = holds + 1;
        if (holds == TOC) begin stage = 0; holds = 0; exp_timeout = 1; end
`endif
      end else begin
        exp_fail = (stage > 0);
        stage = 0; holds = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_progress", progress, stage);
      chk("model_busy", busy, (stage != 0) && !parked);
      chk("model_match", match, exp_match);
      chk("model_done", done, parked);
      chk("model_fail", fail, exp_fail);
      chk("model_timeout", timeout, exp_timeout);
    end
  end

  task automatic cyc(input logic [NI-1:0] v);
    in_vec = v;
    @(negedge clk);
  endtask

  task automatic wr_step(input int a, input logic [NI-1:0] m, input logic [NI-1:0] v);
    cfg_we = 1'b1; cfg_addr = SW'(a); cfg_mask = m; cfg_val = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wr_len(input int l, input logic r);
    cfg_len_we = 1'b1; cfg_len = LW'(l); cfg_rearm = r;
    @(negedge clk);
    cfg_len_we = 1'b0;
  endtask

  task automatic prog_t1();
    wr_step(0, 4'b0100, 4'b0100);
    wr_step(1, 4'b1001, 4'b1001);
    wr_step(2, 4'b0100, 4'b0000);
    wr_len(3, 1'b0);
  endtask

  int nmatch;

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_progress", progress, 0);
    chk("reset_done", done, 0);
    chk("reset_pulses", {match, fail, timeout, busy}, 0);
    reset = 1'b0;

    // Clamp: len 31 -> 16 steps; cleared table matches every cycle.
    wr_len(31, 1'b1);
    for (int i = 0; i < 15; i++) cyc(4'b0000);
    chk("clamp_progress15", progress, 15);
    chk("clamp_nomatch", match, 0);
    cyc(4'b0000);
    chk("clamp_match16", match, 1);
    chk("clamp_wrap", progress, 0);

    // len=1: every C(0) cycle is a match.
    wr_len(1, 1'b1);
    nmatch = 0;
    for (int i = 0; i < 3; i++) begin cyc(4'b1010); nmatch += int'(match); end
    chk("len1_matches", nmatch, 3);

    // Full match, park in done.
    prog_t1();
    cyc(4'b0100); chk("t1_p1", progress, 1);
    cyc(4'b1101); chk("t1_p2", progress, 2);
    cyc(4'b1001); chk("t1_p3", progress, 3);
    chk("t1_match", match, 1);
    chk("t1_done", done, 1);
    cyc(4'b0000); chk("t1_done_hold", done, 1);
    chk("t1_match_once", match, 0);

    // Hold then break.
    wr_len(3, 1'b0);
    cyc(4'b0100); cyc(4'b0100); cyc(4'b0100);
    chk("t2_hold", progress, 1);
    cyc(4'b0000);
    chk("t2_fall", progress, 0);
    chk("t2_fail", fail, 1);

    // Config write beats a same-cycle completion.
    cyc(4'b0100); cyc(4'b1101);
    chk("t4_p2", progress, 2);
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_mask = 4'b0100; cfg_val = 4'b0000;
    cyc(4'b1001);
    cfg_we = 1'b0;
    chk("t4_cleared", progress, 0);
    chk("t4_nomatch", match, 0);
    chk("t4_nofail", fail, 0);

`ifdef HOLD_TIMEOUT_EN
    cyc(4'b0100);
    for (int i = 0; i < 3; i++) cyc(4'b0100);
    chk("to_still_held", progress, 1);
    cyc(4'b0100);
    chk("to_pulse", timeout, 1);
    chk("to_progress", progress, 0);
    chk("to_nofail", fail, 0);
`endif

    // Re-arming two-step sequence.
    wr_step(0, 4'b1111, 4'b0001);
    wr_step(1, 4'b1111, 4'b0010);
    wr_len(2, 1'b1);
    nmatch = 0;
    cyc(4'b0001); chk("t3_p1", progress, 1);
    cyc(4'b0010); nmatch += int'(match); chk("t3_wrap", progress, 0);
    cyc(4'b0001); nmatch += int'(match);
    cyc(4'b0010); nmatch += int'(match);
    chk("t3_matches", nmatch, 2);
    chk("t3_not_done", done, 0);

    // Pseudo-random inputs against the model.
    prog_t1();
    wr_len(3, 1'b1);
    for (int i = 0; i < 60; i++) cyc(4'($urandom_range(0, 15)));

    // Freeze with enable low, then reset mid-sequence.
    wr_len(3, 1'b0);
    cyc(4'b0100); cyc(4'b1101);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000);
      chk("en_frozen", progress, 2);
      chk("en_nopulse", {match, fail, timeout}, 0);
    end
    enable = 1'b1;
    reset = 1'b1;
    cyc(4'b0000);
    chk("rst_all_zero", {progress, busy, match, done, fail, timeout}, 0);
    reset = 1'b0;
    cyc(4'b0000); chk("rst_len0_a", progress, 0);
    cyc(4'b0100); chk("rst_len0_b", progress, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
